v_datamem_banked: RTL
=====================

// Module: v_datamem_banked
// PURPOSE
//  Parametrised, single-clock, NUM_BANKS-way interleaved data memory for the RV32IMC core plus
//  vector coprocessor. Scalar word or full-row vector access from the core port; arbitrated
//  read/write port for protocol controllers; protocol register window plus free-running cycle counter SFR.
//  Inferred RAM (one port per bank); no vendor IP.
// PARAMETERS
//  NUM_BANKS     4       banks = vector lanes; power of 2, >=1; BS = log2(NUM_BANKS)
//  DATA_WIDTH    32      bits per word, multiple of 8; NB = DATA_WIDTH/8 byte enables
//  ROW_BITS      10      rows per bank = 2**ROW_BITS
//  PROTO_WORDS   16      protocol window words, power of 2; PB = log2(PROTO_WORDS)
//  CYCLE_OFFSET  16      window word offset of cycle counter SFR (>= PROTO_WORDS)
//  STARVE_LIMIT  8       consecutive con denials before con gets priority; >=1
//  AW = ROW_BITS+BS+1    word address width; MSB=1 selects protocol window
// PORTS
//  core_clk     in   1                 only clock
//  rst          in   1                 synchronous, active-high reset
//  core_req     in   1                 core access request
//  core_vec     in   1                 1 = vector (all lanes), 0 = scalar (lane 0)
//  core_we      in   NB                byte write enables; 0 = read
//  core_addr    in   AW                word address
//  core_wdata   in   NUM_BANKS*DW      lane i at [i*DW +: DW], big-endian words
//  core_gnt     out  1                 request accepted this cycle (combinational)
//  core_err     out  1                 registered: misaligned vector access rejected
//  core_rvalid  out  1                 registered read data valid
//  core_rdata   out  NUM_BANKS*DW      registered read data, big-endian
//  con_req      in   1                 protocol controller request
//  con_we       in   NB                byte write enables; 0 = read
//  con_addr     in   AW                word address
//  con_wdata    in   DW                big-endian write word
//  con_gnt      out  1                 request accepted this cycle (combinational)
//  con_rvalid   out  1                 registered read data valid
//  con_rdata    out  DW                registered read data, big-endian
// BEHAVIOUR
//  - Storage little-endian: every write byte-reversed on entry, every read byte-reversed on exit.
//  - Core region (MSB=0): word w -> bank w[BS-1:0], row w[BS+ROW_BITS-1:BS].
//  - Scalar: one bank, lane 0 data/enables; read returns word on lane 0, other lanes 0.
//  - Vector: requires w[BS-1:0]==0; lane i -> bank i, same row, same byte enables.
//    Misaligned: granted, no write, core_err=1 and rvalid=1 with rdata=0 next cycle.
//  - Protocol window (MSB=1): offset w[PB-1:0] to PROTO_WORDS registers; core read-only
//    (core writes dropped, no error); con read/write. Offset==CYCLE_OFFSET returns counter on read;
//    writes there dropped. Offsets in [PROTO_WORDS, 2**(AW-1)) other than CYCLE_OFFSET read 0.
//    Vector read of window: value replicated on all lanes.
//  - con writes to core region dropped (granted, no effect); con reads of core region allowed.
//  - Read latency 1: rvalid high exactly the cycle after a granted read; 0 otherwise.
//  - Arbiter FSM {CORE_PRI, CON_PRI}, conflict = core_req & con_req & both target core region.
//    CORE_PRI: conflict -> core_gnt=1, con_gnt=0, starve_cnt++; starve_cnt==STARVE_LIMIT-1 on
//      a denial -> CON_PRI. Any con grant clears starve_cnt.
//    CON_PRI: con_gnt=1, core_gnt=0 on conflict; after one con grant -> CORE_PRI, starve_cnt=0.
//    No conflict: each requester granted. Window accesses never conflict; same-cycle core read
//    and con write of same window word -> core reads old value (read-first).
//  - Cycle counter: DW bits, +1 every cycle after reset, wraps all-ones -> 0.
//  - Reset: outputs 0, FSM CORE_PRI, starve_cnt 0, window regs 0, counter 0; bank RAM not
//    cleared. rst in cycle after a granted read: rvalid stays 0. Requesters hold req until gnt.
// TESTING
//  - Scalar write 0x11223344 be=F to word 5 (N=4), read word 5 -> rvalid next cycle, lane0=0x11223344, lanes1-3=0.
//  - Vector write lanes {A,B,C,D} to word 8, scalar reads words 8..11 -> A,B,C,D; vector read word 9 -> core_err=1, rdata=0.
//  - Byte write be=4'b0100 data 0x00AB0000 over 0xFFFFFFFF -> reads 0xFFABFFFF.
//  - Core and con both request core region for 8 cycles -> con_gnt first in cycle 9, core_gnt=0 that cycle, then core again.
//  - con writes 0xCAFEF00D to window offset 3, core reads same offset -> 0xCAFEF00D; core write there dropped.
//  - Read CYCLE_OFFSET at N and N+5 cycles after reset release -> values differ by 5; rst mid-read -> rvalid 0.

Source files
------------

// File: rtl/v_datamem_banked.sv
// v_datamem_banked: NUM_BANKS-way interleaved data memory with arbitrated controller port, protocol window and cycle counter
// Ports: core_clk, rst (sync, active-high)
//        core_req/vec/we/addr/wdata -> core_gnt (comb), core_err/core_rvalid/core_rdata (registered)
//        con_req/we/addr/wdata      -> con_gnt (comb), con_rvalid/con_rdata (registered)
//        Port words are big-endian; storage is little-endian.
module v_datamem_banked #(
  parameter int NUM_BANKS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROW_BITS = 10,
  parameter int PROTO_WORDS = 16,
  parameter int CYCLE_OFFSET = 16,
  parameter int STARVE_LIMIT = 8,
  localparam int DW = DATA_WIDTH,
  localparam int NB = DW / 8,
  localparam int BS = $clog2(NUM_BANKS),
  localparam int AW = ROW_BITS + BS + 1
) (
  input  logic                    core_clk,
  input  logic                    rst,
  input  logic                    core_req,
  input  logic                    core_vec,
  input  logic [NB-1:0]           core_we,
  input  logic [AW-1:0]           core_addr,
  input  logic [NUM_BANKS*DW-1:0] core_wdata,
  output logic                    core_gnt,
  output logic                    core_err,
  output logic                    core_rvalid,
  output logic [NUM_BANKS*DW-1:0] core_rdata,
  input  logic                    con_req,
  input  logic [NB-1:0]           con_we,
  input  logic [AW-1:0]           con_addr,
  input  logic [DW-1:0]           con_wdata,
  output logic                    con_gnt,
  output logic                    con_rvalid,
  output logic [DW-1:0]           con_rdata
);
  localparam int BSW = BS > 0 ? BS : 1;
  localparam int PB = $clog2(PROTO_WORDS);
  localparam int PBW = PB > 0 ? PB : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int OW = AW - 1;
  typedef enum logic {CORE_PRI, CON_PRI} arb_t;
  function automatic logic [DW-1:0] swap(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int k = 0; k < NB; k++) r[k*8 +: 8] = d[(NB-1-k)*8 +: 8];
    return r;
  endfunction
  function automatic logic [BSW-1:0] bank_of(input logic [AW-1:0] a);
    return BSW'(a % AW'(NUM_BANKS));
  endfunction
  function automatic logic [ROW_BITS-1:0] row_of(input logic [AW-1:0] a);
    return ROW_BITS'(a[OW-1:0] >> BS);
  endfunction
  arb_t state;
  logic [SW-1:0] starve_cnt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] wreg [PROTO_WORDS];
  logic core_win, con_win, conflict, core_mis, core_bacc, con_brd;
  logic [OW-1:0] core_off, con_off;
  logic [BSW-1:0] core_bank, con_bank, core_bank_q, con_bank_q;
  logic [ROW_BITS-1:0] core_row, con_row;
  logic [DW-1:0] core_wv, con_wv, core_wv_q, con_wv_q;
  logic core_rv_q, core_err_q, con_rv_q, core_win_q, core_vec_q, con_win_q;
  logic [NUM_BANKS-1:0] b_en, b_core;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] b_row;
  logic [NUM_BANKS-1:0][NB-1:0] b_we;
  logic [NUM_BANKS-1:0][DW-1:0] b_wd, rd_q;
  assign core_win = core_addr[AW-1];
  assign con_win = con_addr[AW-1];
  assign core_off = core_addr[OW-1:0];
  assign con_off = con_addr[OW-1:0];
  assign core_bank = bank_of(core_addr);
  assign con_bank = bank_of(con_addr);
  assign core_row = row_of(core_addr);
  assign con_row = row_of(con_addr);
  // Only accesses that both land in the banked region compete for bank ports
  assign conflict = core_req & con_req & ~core_win & ~con_win;
  assign core_gnt = core_req & ~rst & ~(conflict & state == CON_PRI);
  assign con_gnt = con_req & ~rst & ~(conflict & state == CORE_PRI);
  assign core_mis = core_vec & ~core_win & (core_bank != '0);
  assign core_bacc = core_gnt & ~core_win & ~core_mis;
  assign con_brd = con_gnt & ~con_win & ~|con_we;
  assign core_wv = core_off < OW'(PROTO_WORDS) ? swap(wreg[PBW'(core_off)]) : core_off == OW'(CYCLE_OFFSET) ? cnt : '0;
  assign con_wv = con_off < OW'(PROTO_WORDS) ? swap(wreg[PBW'(con_off)]) : con_off == OW'(CYCLE_OFFSET) ? cnt : '0;
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      b_core[i] = core_bacc & (core_vec | core_bank == BSW'(i));
      b_en[i] = b_core[i] | (con_brd & con_bank == BSW'(i));
      b_row[i] = b_core[i] ? core_row : con_row;
      b_we[i] = b_core[i] ? core_we : '0;
      b_wd[i] = core_vec ? core_wdata[i*DW +: DW] : core_wdata[DW-1:0];
    end
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DW-1:0] mem [2**ROW_BITS];
    logic [DW-1:0] rd;
    always_ff @(posedge core_clk) begin
      for (int k = 0; k < NB; k++)
        if (b_we[b][k]) mem[b_row[b]][(NB-1-k)*8 +: 8] <= b_wd[b][k*8 +: 8];
      if (b_en[b]) rd <= mem[b_row[b]];
    end
    assign rd_q[b] = rd;
  end
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state <= CORE_PRI;
      starve_cnt <= '0;
      cnt <= '0;
      core_rv_q <= 1'b0;
      core_err_q <= 1'b0;
      con_rv_q <= 1'b0;
      for (int i = 0; i < PROTO_WORDS; i++) wreg[i] <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      core_rv_q <= core_gnt & (~|core_we | core_mis);
      core_err_q <= core_gnt & core_mis;
      con_rv_q <= con_gnt & ~|con_we;
      if (con_gnt & con_win & con_off < OW'(PROTO_WORDS))
        for (int k = 0; k < NB; k++)
          if (con_we[k]) wreg[PBW'(con_off)][(NB-1-k)*8 +: 8] <= con_wdata[k*8 +: 8];
      if (state == CORE_PRI) begin
        if (conflict) begin
          starve_cnt <= starve_cnt == SW'(STARVE_LIMIT - 1) ? '0 : starve_cnt + 1'b1;
          if (starve_cnt == SW'(STARVE_LIMIT - 1)) state <= CON_PRI;
        end else if (con_gnt) starve_cnt <= '0;
      end else if (con_gnt) begin
        state <= CORE_PRI;
        starve_cnt <= '0;
      end
    end
    core_win_q <= core_win;
    core_vec_q <= core_vec;
    core_bank_q <= core_bank;
    core_wv_q <= core_wv;
    con_win_q <= con_win;
    con_bank_q <= con_bank;
    con_wv_q <= con_wv;
  end
  // Reset also masks a response already in flight
  assign core_rvalid = core_rv_q & ~rst;
  assign core_err = core_err_q & ~rst;
  assign con_rvalid = con_rv_q & ~rst;
  always_comb begin
    core_rdata = '0;
    if (core_rvalid & ~core_err_q)
      for (int i = 0; i < NUM_BANKS; i++)
        if (core_vec_q | i == 0)
          core_rdata[i*DW +: DW] = core_win_q ? core_wv_q : swap(core_vec_q ? rd_q[i] : rd_q[core_bank_q]);
  end
  assign con_rdata = con_rvalid ? (con_win_q ? con_wv_q : swap(rd_q[con_bank_q])) : '0;
endmodule
